// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: command sequencer in front of the dc_motor PWM block.
// Drives psw = {dir, duty level}. Accepts speed/direction commands over
// valid/ready. Ramps the duty level one step per RAMP_TICKS cycles.
// Every direction reversal passes through level 0 plus a DWELL_TICKS dwell.
// estop forces level 0 immediately and latches a sticky fault flag.
// Optional feature: define MOTOR_CMD_WDT_EN to enable the command watchdog.
// The watchdog ramps the motor down to 0 when no command arrives for
// WDT_TICKS cycles while the motor is not idle.
module motor_ramp_ctrl #(
    parameter int unsigned RAMP_TICKS  = 1_000_000,
    parameter int unsigned DWELL_TICKS = 2_500_000,
    parameter int unsigned CNT_W       = 22,
    parameter int unsigned WDT_TICKS   = 50_000_000,
    parameter int unsigned WDT_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_level,
    input  logic       cmd_dir,
    input  logic       estop,
    output logic [2:0] psw,
    output logic       busy,
    output logic       fault,
    output logic       wdt_trip
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RAMP_UP = 3'd2,
        ST_RAMP_DN = 3'd3,
        ST_DWELL   = 3'd4,
        ST_ESTOP   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RAMP_LOAD  = CNT_W'(RAMP_TICKS - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_TICKS - 1);

    state_t           state_r;
    logic             cur_dir_r;
    logic [1:0]       cur_level_r;
    logic             tgt_dir_r;
    logic [1:0]       tgt_level_r;
    logic             rev_pend_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fault_r;
    logic             ready_r;
    logic             busy_r;

    logic             xfer_s;
    logic [1:0]       goal_s;
    logic [1:0]       lvl_up_s;
    logic [1:0]       lvl_dn_s;
    logic             wdt_hit_s;

    // ready_r is only set in IDLE/HOLD. estop masks it directly so that
    // no command looks accepted on an edge where estop wins.
    assign cmd_ready = ready_r & ~estop;
    assign psw       = {cur_dir_r, cur_level_r};
    assign busy      = busy_r;
    assign fault     = fault_r;

    // Handshake transfer and saturating next-level values for the ramps.
    always_comb begin
        xfer_s   = cmd_valid & ready_r & ~estop;
        goal_s   = rev_pend_r ? 2'd0 : tgt_level_r;
        lvl_up_s = (cur_level_r != 2'd3)   ? (cur_level_r + 2'd1) : cur_level_r;
        lvl_dn_s = (cur_level_r > goal_s)  ? (cur_level_r - 2'd1) : cur_level_r;
    end

`ifdef MOTOR_CMD_WDT_EN
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TICKS - 1);

    logic [WDT_W-1:0] wdt_cnt_r;
    logic             wdt_trip_r;
    logic             wdt_run_s;

    // The watchdog runs only while the motor is not idle and no command or estop
    // is being taken this cycle.
    always_comb begin
        wdt_run_s = ((state_r == ST_HOLD) || (state_r == ST_RAMP_UP) ||
                     (state_r == ST_RAMP_DN) || (state_r == ST_DWELL)) &&
                    !xfer_s && !estop;
        wdt_hit_s = wdt_run_s && (wdt_cnt_r == WDT_LAST);
    end

    // Watchdog counter and its one-cycle expiry pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdt_cnt_r  <= '0;
            wdt_trip_r <= 1'b0;
        end else begin
            if (!wdt_run_s || wdt_hit_s) begin
                wdt_cnt_r <= '0;
            end else begin
                wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
            end
            wdt_trip_r <= wdt_hit_s;
        end
    end

    assign wdt_trip = wdt_trip_r;
`else
    assign wdt_hit_s = 1'b0;
    assign wdt_trip  = 1'b0;

    // Watchdog parameters stay in the interface so both builds share one instantiation.
    if ((WDT_TICKS < 1) || (WDT_W < 1)) begin : g_wdt_cfg_unused
    end
`endif

    // Main sequencer: estop first, then watchdog, then handshake and ramp/dwell timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cur_dir_r   <= 1'b0;
            cur_level_r <= 2'd0;
            tgt_dir_r   <= 1'b0;
            tgt_level_r <= 2'd0;
            rev_pend_r  <= 1'b0;
            cnt_r       <= '0;
            fault_r     <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
        end else if (estop) begin
            state_r     <= ST_ESTOP;
            cur_level_r <= 2'd0;
            rev_pend_r  <= 1'b0;
            cnt_r       <= '0;
            fault_r     <= 1'b1;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else if (wdt_hit_s) begin
            // Command stream went silent: ramp down in the current direction.
            tgt_dir_r   <= cur_dir_r;
            tgt_level_r <= 2'd0;
            rev_pend_r  <= 1'b0;
            state_r     <= ST_RAMP_DN;
            cnt_r       <= RAMP_LOAD;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (xfer_s) begin
                        tgt_dir_r   <= cmd_dir;
                        tgt_level_r <= cmd_level;
                        fault_r     <= 1'b0;
                        if ((cmd_dir == cur_dir_r) || (cur_level_r == 2'd0)) begin
                            cur_dir_r  <= cmd_dir;
                            rev_pend_r <= 1'b0;
                            if (cmd_level > cur_level_r) begin
                                state_r <= ST_RAMP_UP;
                                cnt_r   <= RAMP_LOAD;
                                ready_r <= 1'b0;
                                busy_r  <= 1'b1;
                            end else if (cmd_level < cur_level_r) begin
                                state_r <= ST_RAMP_DN;
                                cnt_r   <= RAMP_LOAD;
                                ready_r <= 1'b0;
                                busy_r  <= 1'b1;
                            end else begin
                                state_r <= state_r;
                            end
                        end else begin
                            // Reversal while moving: go through zero and a dwell first.
                            rev_pend_r <= 1'b1;
                            state_r    <= ST_RAMP_DN;
                            cnt_r      <= RAMP_LOAD;
                            ready_r    <= 1'b0;
                            busy_r     <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RAMP_UP: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        cur_level_r <= lvl_up_s;
                        if (lvl_up_s >= tgt_level_r) begin
                            state_r <= ST_HOLD;
                            cnt_r   <= '0;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= RAMP_LOAD;
                        end
                    end
                end
                ST_RAMP_DN: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        cur_level_r <= lvl_dn_s;
                        if (lvl_dn_s <= goal_s) begin
                            if (rev_pend_r) begin
                                state_r <= ST_DWELL;
                                cnt_r   <= DWELL_LOAD;
                            end else begin
                                state_r <= (lvl_dn_s == 2'd0) ? ST_IDLE : ST_HOLD;
                                cnt_r   <= '0;
                                ready_r <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r <= RAMP_LOAD;
                        end
                    end
                end
                ST_DWELL: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        cur_dir_r  <= tgt_dir_r;
                        rev_pend_r <= 1'b0;
                        if (tgt_level_r != 2'd0) begin
                            state_r <= ST_RAMP_UP;
                            cnt_r   <= RAMP_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                            cnt_r   <= '0;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_ESTOP: begin
                    // estop has dropped (it is handled above while high).
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cur_level_r <= 2'd0;
                    rev_pend_r  <= 1'b0;
                    cnt_r       <= '0;
                    ready_r     <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
